// File: rtl/y86_defs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : y86_defs                                                         |
// | Shared Y86-64 encodings (instruction codes, register ids, status codes)    |
// | and the decode helpers that turn icode/rA/rB into pipeline register ids.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package y86_defs;

  // Instruction codes
  localparam logic [3:0] c_I_HALT  = 4'h0;
  localparam logic [3:0] c_I_NOP   = 4'h1;
  localparam logic [3:0] c_I_CMOV  = 4'h2;
  localparam logic [3:0] c_I_IRMOV = 4'h3;
  localparam logic [3:0] c_I_RMMOV = 4'h4;
  localparam logic [3:0] c_I_MRMOV = 4'h5;
  localparam logic [3:0] c_I_OPQ   = 4'h6;
  localparam logic [3:0] c_I_JXX   = 4'h7;
  localparam logic [3:0] c_I_CALL  = 4'h8;
  localparam logic [3:0] c_I_RET   = 4'h9;
  localparam logic [3:0] c_I_PUSH  = 4'hA;
  localparam logic [3:0] c_I_POP   = 4'hB;

  // Register identifiers
  localparam logic [3:0] c_RNONE = 4'hF;
  localparam logic [3:0] c_RSP   = 4'h4;

  // Status codes
  localparam logic [2:0] c_S_AOK = 3'd1;
  localparam logic [2:0] c_S_HLT = 3'd2;
  localparam logic [2:0] c_S_ADR = 3'd3;
  localparam logic [2:0] c_S_INS = 3'd4;

  function automatic logic [3:0] f_src_a(input logic [3:0] icode, input logic [3:0] ra);
    case (icode)
      c_I_CMOV, c_I_RMMOV, c_I_OPQ, c_I_PUSH: f_src_a = ra;
      c_I_POP, c_I_RET:                       f_src_a = c_RSP;
      default:                                f_src_a = c_RNONE;
    endcase
  endfunction

  function automatic logic [3:0] f_src_b(input logic [3:0] icode, input logic [3:0] rb);
    case (icode)
      c_I_RMMOV, c_I_MRMOV, c_I_OPQ:          f_src_b = rb;
      c_I_PUSH, c_I_POP, c_I_CALL, c_I_RET:   f_src_b = c_RSP;
      default:                                f_src_b = c_RNONE;
    endcase
  endfunction

  function automatic logic [3:0] f_dst_e(input logic [3:0] icode, input logic [3:0] rb);
    case (icode)
      c_I_CMOV, c_I_IRMOV, c_I_OPQ:           f_dst_e = rb;
      c_I_PUSH, c_I_POP, c_I_CALL, c_I_RET:   f_dst_e = c_RSP;
      default:                                f_dst_e = c_RNONE;
    endcase
  endfunction

  function automatic logic [3:0] f_dst_m(input logic [3:0] icode, input logic [3:0] ra);
    case (icode)
      c_I_MRMOV, c_I_POP: f_dst_m = ra;
      default:            f_dst_m = c_RNONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_exec_reg_fwd_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fwd_sel                                                          |
// | Forwarding mux for one decode operand. Picks the youngest in-flight       |
// | producer of i_src, falling back to the register-file read.                |
// | Ports   : i_src/i_rval (operand id and regfile value), five (dst,val)      |
// |           producer pairs ordered youngest first, o_val (forwarded value). |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module fwd_sel
  import y86_defs::*;
#(
  parameter int W_DATA = 64
) (
  input  logic [3:0]        i_src,
  input  logic [W_DATA-1:0] i_rval,
  input  logic [3:0]        i_e_dstE,
  input  logic [W_DATA-1:0] i_e_valE,
  input  logic [3:0]        i_m_dstM,
  input  logic [W_DATA-1:0] i_m_valM,
  input  logic [3:0]        i_M_dstE,
  input  logic [W_DATA-1:0] i_M_valE,
  input  logic [3:0]        i_W_dstM,
  input  logic [W_DATA-1:0] i_W_valM,
  input  logic [3:0]        i_W_dstE,
  input  logic [W_DATA-1:0] i_W_valE,
  output logic [W_DATA-1:0] o_val
);

  // Gating on i_src != RNONE is enough to stop an RNONE producer matching:
  // equality with a non-RNONE source implies the producer is not RNONE.
  always_comb begin
    o_val = i_rval;
    if (i_src != c_RNONE) begin
      if (i_e_dstE == i_src)      o_val = i_e_valE;
      else if (i_m_dstM == i_src) o_val = i_m_valM;
      else if (i_M_dstE == i_src) o_val = i_M_valE;
      else if (i_W_dstM == i_src) o_val = i_W_valM;
      else if (i_W_dstE == i_src) o_val = i_W_valE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/decode_exec_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : decode_exec_reg                                                  |
// | D->E pipeline register of the pipelined Y86-64 core. Decodes register ids, |
// | forwards valA/valB and latches them into E with stall/bubble control,     |
// | a saturating bubble counter and a sticky control-error flag.              |
// | Ports   : clk/rst, e_stall/e_bubble control, D-stage fields and regfile    |
// |           reads, E/M/W forward sources, combinational d_srcA/d_srcB,      |
// |           registered E_* fields, bubble_cnt, ctrl_err.                    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module decode_exec_reg
  import y86_defs::*;
#(
  parameter int W_DATA = 64,
  parameter int W_CNT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              e_stall,
  input  logic              e_bubble,
  input  logic [2:0]        d_stat,
  input  logic [3:0]        d_icode,
  input  logic [3:0]        d_ifun,
  input  logic [3:0]        d_rA,
  input  logic [3:0]        d_rB,
  input  logic [W_DATA-1:0] d_valC,
  input  logic [W_DATA-1:0] d_valP,
  input  logic [W_DATA-1:0] d_rvalA,
  input  logic [W_DATA-1:0] d_rvalB,
  input  logic [3:0]        e_dstE,
  input  logic [W_DATA-1:0] e_valE,
  input  logic [3:0]        m_dstM,
  input  logic [W_DATA-1:0] m_valM,
  input  logic [3:0]        M_dstE,
  input  logic [W_DATA-1:0] M_valE,
  input  logic [3:0]        W_dstM,
  input  logic [W_DATA-1:0] W_valM,
  input  logic [3:0]        W_dstE,
  input  logic [W_DATA-1:0] W_valE,
  output logic [3:0]        d_srcA,
  output logic [3:0]        d_srcB,
  output logic [2:0]        E_stat,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [W_DATA-1:0] E_valC,
  output logic [W_DATA-1:0] E_valA,
  output logic [W_DATA-1:0] E_valB,
  output logic [3:0]        E_dstE,
  output logic [3:0]        E_dstM,
  output logic [3:0]        E_srcA,
  output logic [3:0]        E_srcB,
  output logic [W_CNT-1:0]  bubble_cnt,
  output logic              ctrl_err
);

  localparam logic [W_CNT-1:0] c_CNT_ONE = {{(W_CNT-1){1'b0}}, 1'b1};

  logic [3:0]        w_srcA;
  logic [3:0]        w_srcB;
  logic [3:0]        w_dstE;
  logic [3:0]        w_dstM;
  logic [W_DATA-1:0] w_fwdA;
  logic [W_DATA-1:0] w_fwdB;
  logic [W_DATA-1:0] w_valA;
  logic              w_use_valP;

  logic [2:0]        r_stat;
  logic [3:0]        r_icode;
  logic [3:0]        r_ifun;
  logic [W_DATA-1:0] r_valC;
  logic [W_DATA-1:0] r_valA;
  logic [W_DATA-1:0] r_valB;
  logic [3:0]        r_dstE;
  logic [3:0]        r_dstM;
  logic [3:0]        r_srcA;
  logic [3:0]        r_srcB;
  logic [W_CNT-1:0]  r_bubble_cnt;
  logic              r_ctrl_err;

  assign w_srcA = f_src_a(d_icode, d_rA);
  assign w_srcB = f_src_b(d_icode, d_rB);
  assign w_dstE = f_dst_e(d_icode, d_rB);
  assign w_dstM = f_dst_m(d_icode, d_rA);

  fwd_sel #(.W_DATA(W_DATA)) u_fwd_a (
    .i_src    (w_srcA),
    .i_rval   (d_rvalA),
    .i_e_dstE (e_dstE), .i_e_valE (e_valE),
    .i_m_dstM (m_dstM), .i_m_valM (m_valM),
    .i_M_dstE (M_dstE), .i_M_valE (M_valE),
    .i_W_dstM (W_dstM), .i_W_valM (W_valM),
    .i_W_dstE (W_dstE), .i_W_valE (W_valE),
    .o_val    (w_fwdA)
  );

  fwd_sel #(.W_DATA(W_DATA)) u_fwd_b (
    .i_src    (w_srcB),
    .i_rval   (d_rvalB),
    .i_e_dstE (e_dstE), .i_e_valE (e_valE),
    .i_m_dstM (m_dstM), .i_m_valM (m_valM),
    .i_M_dstE (M_dstE), .i_M_valE (M_valE),
    .i_W_dstM (W_dstM), .i_W_valM (W_valM),
    .i_W_dstE (W_dstE), .i_W_valE (W_valE),
    .o_val    (w_fwdB)
  );

  // call/jXX carry the return/fall-through address down the pipe in valA.
  assign w_use_valP = (d_icode == c_I_CALL) || (d_icode == c_I_JXX);
  assign w_valA     = w_use_valP ? d_valP : w_fwdA;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat       <= c_S_AOK;
      r_icode      <= c_I_NOP;
      r_ifun       <= 4'h0;
      r_valC       <= '0;
      r_valA       <= '0;
      r_valB       <= '0;
      r_dstE       <= c_RNONE;
      r_dstM       <= c_RNONE;
      r_srcA       <= c_RNONE;
      r_srcB       <= c_RNONE;
      r_bubble_cnt <= '0;
      r_ctrl_err   <= 1'b0;
    end else if (e_stall) begin
      // Stall wins over a simultaneous bubble; the conflict is latched.
      if (e_bubble) r_ctrl_err <= 1'b1;
    end else if (e_bubble) begin
      r_stat  <= c_S_AOK;
      r_icode <= c_I_NOP;
      r_ifun  <= 4'h0;
      r_valC  <= '0;
      r_valA  <= '0;
      r_valB  <= '0;
      r_dstE  <= c_RNONE;
      r_dstM  <= c_RNONE;
      r_srcA  <= c_RNONE;
      r_srcB  <= c_RNONE;
      if (r_bubble_cnt != {W_CNT{1'b1}}) r_bubble_cnt <= r_bubble_cnt + c_CNT_ONE;
    end else begin
      r_stat  <= d_stat;
      r_icode <= d_icode;
      r_ifun  <= d_ifun;
      r_valC  <= d_valC;
      r_valA  <= w_valA;
      r_valB  <= w_fwdB;
      r_dstE  <= w_dstE;
      r_dstM  <= w_dstM;
      r_srcA  <= w_srcA;
      r_srcB  <= w_srcB;
    end
  end

  assign d_srcA     = w_srcA;
  assign d_srcB     = w_srcB;
  assign E_stat     = r_stat;
  assign E_icode    = r_icode;
  assign E_ifun     = r_ifun;
  assign E_valC     = r_valC;
  assign E_valA     = r_valA;
  assign E_valB     = r_valB;
  assign E_dstE     = r_dstE;
  assign E_dstM     = r_dstM;
  assign E_srcA     = r_srcA;
  assign E_srcB     = r_srcB;
  assign bubble_cnt = r_bubble_cnt;
  assign ctrl_err   = r_ctrl_err;

endmodule
`default_nettype wire
